// File: rtl/bus_bridge_gen_if.sv
// CPU-side and slot-side signal bundle for the bus bridge.
// The bridge connects through the slave modport and the environment through the master modport.
interface bus_bridge_gen_if #(
  parameter int SLOT_BITS = 3,
  parameter int REG_BITS  = 4,
  parameter int ADDR_W    = 19
);
  localparam int NSLOT = 2 ** SLOT_BITS;

  logic                  as_n;
  logic                  uds_n;
  logic                  lds_n;
  logic                  rw;
  logic [2:0]            cpu_fc;
  logic                  fpga_cs_n;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [15:0]           cpu_wdata;
  logic [15:0]           cpu_rdata;
  logic                  oe_h;
  logic                  oe_l;
  logic                  dtack_n;
  logic                  berr_n;
  logic                  vpa_n;
  logic [7:0]            intr_vector;
  logic                  intr_dtack_n;
  logic                  intr_vpa_n;
  logic [NSLOT-1:0]      s_sel;
  logic                  s_stb;
  logic [REG_BITS-1:0]   s_addr;
  logic                  s_we;
  logic [1:0]            s_be;
  logic [15:0]           s_wdata;
  logic [NSLOT*16-1:0]   s_rdata;
  logic [NSLOT-1:0]      s_ack;

  modport master (
    output as_n, uds_n, lds_n, rw, cpu_fc, fpga_cs_n, cpu_addr, cpu_wdata,
    output intr_vector, intr_dtack_n, intr_vpa_n, s_rdata, s_ack,
    input  cpu_rdata, oe_h, oe_l, dtack_n, berr_n, vpa_n,
    input  s_sel, s_stb, s_addr, s_we, s_be, s_wdata
  );

  modport slave (
    input  as_n, uds_n, lds_n, rw, cpu_fc, fpga_cs_n, cpu_addr, cpu_wdata,
    input  intr_vector, intr_dtack_n, intr_vpa_n, s_rdata, s_ack,
    output cpu_rdata, oe_h, oe_l, dtack_n, berr_n, vpa_n,
    output s_sel, s_stb, s_addr, s_we, s_be, s_wdata
  );
endinterface

// File: rtl/bus_bridge_gen.sv
// Asynchronous CPU bus to slotted register bus bridge: decodes a strobe into a slot access,
// completes on fixed wait or slave ack (with timeout), and passes interrupt-acknowledge cycles through.
module bus_bridge_gen #(
  parameter int                      SLOT_BITS = 3,
  parameter int                      REG_BITS  = 4,
  parameter int                      ADDR_W    = 19,
  parameter logic [2**SLOT_BITS-1:0] ACK_MASK  = '0,
  parameter int                      WAIT_CYC  = 2,
  parameter int                      TIMEOUT   = 255
) (
  input logic             clk,
  input logic             rst,
  bus_bridge_gen_if.slave bus
);
  localparam int NSLOT  = 2 ** SLOT_BITS;
  localparam int DEC_LO = SLOT_BITS + REG_BITS;
  localparam logic [9:0] WAIT_LAST = 10'(WAIT_CYC);
  localparam logic [9:0] TO_LAST   = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ACCESS, DONE, BERR, IACK} state_e;

  state_e               state_q, state_d;
  logic                 as_meta_q, as_meta_d;
  logic                 as_s_q, as_s_d;
  logic [1:0]           sync_vld_q, sync_vld_d;
  logic                 armed_q, armed_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [REG_BITS-1:0]  s_addr_q, s_addr_d;
  logic                 s_we_q, s_we_d;
  logic [1:0]           s_be_q, s_be_d;
  logic [15:0]          s_wdata_q, s_wdata_d;
  logic [15:0]          cpu_rdata_q, cpu_rdata_d;
  logic [9:0]           cnt_q, cnt_d;
  logic [NSLOT-1:0]     s_sel_q, s_sel_d;
  logic                 s_stb_q, s_stb_d;
  logic                 dtack_n_q, dtack_n_d;
  logic                 berr_n_q, berr_n_d;

  logic strobe_any, unmapped, ack_slot, ack_hit;

  always_comb begin
    strobe_any = ~bus.uds_n | ~bus.lds_n;
    unmapped   = |bus.cpu_addr[ADDR_W-1:DEC_LO];
    ack_slot   = ACK_MASK[slot_q];
    ack_hit    = bus.s_ack[slot_q];
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    armed_d     = armed_q;
    slot_d      = slot_q;
    s_addr_d    = s_addr_q;
    s_we_d      = s_we_q;
    s_be_d      = s_be_q;
    s_wdata_d   = s_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    cnt_d       = '0;
    as_meta_d   = bus.as_n;
    as_s_d      = as_meta_q;
    sync_vld_d  = {sync_vld_q[0], 1'b1};

    // Only a genuinely synchronised strobe-high (not the reset value) re-arms decode.
    if (as_s_q && sync_vld_q[1]) armed_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (armed_q && !as_s_q) begin
          if (bus.cpu_fc == 3'b111) begin
            state_d = IACK;
          end else if (!bus.fpga_cs_n && strobe_any) begin
            if (unmapped) begin
              state_d = BERR;
            end else begin
              state_d   = ACCESS;
              slot_d    = bus.cpu_addr[DEC_LO-1:REG_BITS];
              s_addr_d  = bus.cpu_addr[REG_BITS-1:0];
              s_we_d    = ~bus.rw;
              s_be_d    = {~bus.uds_n, ~bus.lds_n};
              s_wdata_d = bus.cpu_wdata;
            end
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 10'd1;
        if (as_s_q) begin
          state_d = IDLE;
        end else if (ack_slot) begin
          if (ack_hit)                 state_d = DONE;
          else if (cnt_q == TO_LAST)   state_d = BERR;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = DONE;
        end
        if (state_d == DONE && !s_we_q)
          cpu_rdata_d = bus.s_rdata[16*int'(slot_q) +: 16];
      end
      DONE, BERR, IACK: begin
        if (as_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE && state_d != IDLE) armed_d = 1'b0;

    s_sel_d = '0;
    if (state_d == ACCESS) s_sel_d[slot_d] = 1'b1;
    s_stb_d   = (state_q == IDLE) && (state_d == ACCESS);
    dtack_n_d = (state_d != DONE);
    berr_n_d  = (state_d != BERR);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      as_meta_q   <= 1'b1;
      as_s_q      <= 1'b1;
      sync_vld_q  <= '0;
      armed_q     <= 1'b0;
      slot_q      <= '0;
      s_addr_q    <= '0;
      s_we_q      <= 1'b0;
      s_be_q      <= '0;
      s_wdata_q   <= '0;
      cpu_rdata_q <= 16'hFFFF;
      cnt_q       <= '0;
      s_sel_q     <= '0;
      s_stb_q     <= 1'b0;
      dtack_n_q   <= 1'b1;
      berr_n_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      as_meta_q   <= as_meta_d;
      as_s_q      <= as_s_d;
      sync_vld_q  <= sync_vld_d;
      armed_q     <= armed_d;
      slot_q      <= slot_d;
      s_addr_q    <= s_addr_d;
      s_we_q      <= s_we_d;
      s_be_q      <= s_be_d;
      s_wdata_q   <= s_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      cnt_q       <= cnt_d;
      s_sel_q     <= s_sel_d;
      s_stb_q     <= s_stb_d;
      dtack_n_q   <= dtack_n_d;
      berr_n_q    <= berr_n_d;
    end
  end

  // Interrupt-acknowledge handshakes and vector bypass the registers.
  assign bus.s_sel     = s_sel_q;
  assign bus.s_stb     = s_stb_q;
  assign bus.s_addr    = s_addr_q;
  assign bus.s_we      = s_we_q;
  assign bus.s_be      = s_be_q;
  assign bus.s_wdata   = s_wdata_q;
  assign bus.berr_n    = berr_n_q;
  assign bus.dtack_n   = (state_q == IACK) ? bus.intr_dtack_n : dtack_n_q;
  assign bus.vpa_n     = (state_q == IACK) ? bus.intr_vpa_n : 1'b1;
  assign bus.cpu_rdata = (state_q == IACK) ? {cpu_rdata_q[15:8], bus.intr_vector} : cpu_rdata_q;
  assign bus.oe_h      = (state_q == DONE) & ~s_we_q & s_be_q[1];
  assign bus.oe_l      = (state_q == IACK) | ((state_q == DONE) & ~s_we_q & s_be_q[0]);
endmodule

// File: tb/tb_bus_bridge_gen.sv
// Directed bench for bus_bridge_gen: fixed-wait and ack slots, timeout, unmapped, IACK, abort, reset.
module tb_bus_bridge_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  bus_bridge_gen_if #(.SLOT_BITS(3), .REG_BITS(4), .ADDR_W(19)) bus ();

  bus_bridge_gen #(
    .SLOT_BITS(3), .REG_BITS(4), .ADDR_W(19),
    .ACK_MASK(8'h02), .WAIT_CYC(2), .TIMEOUT(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_cycle(input logic [18:0] addr, input logic rw, input logic uds_n,
                             input logic lds_n, input logic [15:0] wdata);
    bus.cpu_addr  = addr;
    bus.rw        = rw;
    bus.uds_n     = uds_n;
    bus.lds_n     = lds_n;
    bus.cpu_wdata = wdata;
    bus.fpga_cs_n = 1'b0;
    bus.as_n      = 1'b0;
  endtask

  task automatic end_cycle(input string name);
    bit idle_seen = 0;
    bus.as_n  = 1'b1;
    bus.uds_n = 1'b1;
    bus.lds_n = 1'b1;
    bus.fpga_cs_n = 1'b1;
    for (int c = 0; c < 10 && !idle_seen; c++) begin
      tick();
      if (bus.dtack_n === 1'b1 && bus.berr_n === 1'b1 && bus.oe_l === 1'b0 && bus.oe_h === 1'b0)
        idle_seen = 1;
    end
    n_checks++;
    if (!idle_seen) begin
      n_fails++;
      $display("FAIL %s_release: dtack_n=%b berr_n=%b oe_h=%b oe_l=%b want 1 1 0 0",
               name, bus.dtack_n, bus.berr_n, bus.oe_h, bus.oe_l);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_checks++;
    if ({bus.dtack_n, bus.berr_n, bus.vpa_n, bus.oe_h, bus.oe_l} !== 5'b11100) begin
      n_fails++;
      $display("FAIL reset_handshakes: got %b want 11100",
               {bus.dtack_n, bus.berr_n, bus.vpa_n, bus.oe_h, bus.oe_l});
    end
    n_checks++;
    if ({bus.s_sel, bus.s_stb, bus.s_we, bus.s_be, bus.s_addr} !== 16'h0000) begin
      n_fails++;
      $display("FAIL reset_slave_ctl: sel=%h stb=%b we=%b be=%b addr=%h want all zero",
               bus.s_sel, bus.s_stb, bus.s_we, bus.s_be, bus.s_addr);
    end
    n_checks++;
    if (bus.s_wdata !== 16'h0000 || bus.cpu_rdata !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL reset_data: s_wdata=%h cpu_rdata=%h want 0000 FFFF", bus.s_wdata, bus.cpu_rdata);
    end
    rst = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_fixed_read(input logic [18:0] addr, input logic [7:0] exp_sel,
                                 input logic [15:0] exp_data, input string name);
    int sel_cnt = 0, stb_cnt = 0, last_sel = -1, dt_cyc = -1;
    bit bad_sel = 0;
    begin_cycle(addr, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int c = 0; c < 30 && dt_cyc < 0; c++) begin
      tick();
      if (bus.s_sel === exp_sel) begin
        sel_cnt++;
        last_sel = c;
      end else if (bus.s_sel !== 8'h00) bad_sel = 1;
      if (bus.s_stb === 1'b1) stb_cnt++;
      if (bus.dtack_n === 1'b0) dt_cyc = c;
    end
    n_checks++;
    if (sel_cnt !== 3 || bad_sel) begin
      n_fails++;
      $display("FAIL %s_sel_cycles: got %0d (stray=%0d) want 3", name, sel_cnt, bad_sel);
    end
    n_checks++;
    if (stb_cnt !== 1) begin
      n_fails++;
      $display("FAIL %s_stb_cycles: got %0d want 1", name, stb_cnt);
    end
    n_checks++;
    if (dt_cyc < 0 || dt_cyc !== last_sel + 1) begin
      n_fails++;
      $display("FAIL %s_dtack_timing: dtack cycle %0d last sel cycle %0d want sel+1", name, dt_cyc, last_sel);
    end
    n_checks++;
    if (bus.cpu_rdata !== exp_data) begin
      n_fails++;
      $display("FAIL %s_rdata: got %h want %h", name, bus.cpu_rdata, exp_data);
    end
    n_checks++;
    if (bus.oe_h !== 1'b1 || bus.oe_l !== 1'b1 || bus.berr_n !== 1'b1) begin
      n_fails++;
      $display("FAIL %s_oe: oe_h=%b oe_l=%b berr_n=%b want 1 1 1", name, bus.oe_h, bus.oe_l, bus.berr_n);
    end
    end_cycle(name);
  endtask

  task automatic test_ack_write();
    bit found = 0, early = 0;
    begin_cycle(19'h13, 1'b0, 1'b0, 1'b1, 16'hAB00);
    bus.s_ack = 8'hFD;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (bus.s_sel === 8'h02) found = 1;
    end
    n_checks++;
    if (!found || bus.s_stb !== 1'b1) begin
      n_fails++;
      $display("FAIL wr_start: sel=%h stb=%b want 02 1", bus.s_sel, bus.s_stb);
    end
    n_checks++;
    if ({bus.s_we, bus.s_be, bus.s_addr, bus.s_wdata} !== {1'b1, 2'b10, 4'h3, 16'hAB00}) begin
      n_fails++;
      $display("FAIL wr_fields: we=%b be=%b addr=%h wdata=%h want 1 10 3 ab00",
               bus.s_we, bus.s_be, bus.s_addr, bus.s_wdata);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.dtack_n !== 1'b1 || bus.s_sel !== 8'h02) early = 1;
    end
    n_checks++;
    if (early) begin
      n_fails++;
      $display("FAIL wr_wait_for_ack: dtack_n=%b sel=%h want 1 02 before ack", bus.dtack_n, bus.s_sel);
    end
    bus.s_ack = 8'hFF;
    tick();
    bus.s_ack = 8'h00;
    n_checks++;
    if (bus.dtack_n !== 1'b0 || bus.s_sel !== 8'h00) begin
      n_fails++;
      $display("FAIL wr_dtack: dtack_n=%b sel=%h want 0 00", bus.dtack_n, bus.s_sel);
    end
    n_checks++;
    if (bus.oe_h !== 1'b0 || bus.oe_l !== 1'b0) begin
      n_fails++;
      $display("FAIL wr_oe: oe_h=%b oe_l=%b want 0 0", bus.oe_h, bus.oe_l);
    end
    end_cycle("wr");
  endtask

  task automatic test_timeout();
    bit found = 0, dt_low = 0;
    int n = 0;
    begin_cycle(19'h10, 1'b1, 1'b0, 1'b0, 16'h0000);
    bus.s_ack = 8'hFD;
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (bus.s_sel === 8'h02) found = 1;
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      n++;
      if (bus.dtack_n !== 1'b1) dt_low = 1;
      if (bus.berr_n === 1'b0) break;
    end
    n_checks++;
    if (!found || n !== 10 || bus.berr_n !== 1'b0) begin
      n_fails++;
      $display("FAIL to_berr_cycles: got %0d (berr_n=%b started=%0d) want 10", n, bus.berr_n, found);
    end
    n_checks++;
    if (dt_low || bus.s_sel !== 8'h00) begin
      n_fails++;
      $display("FAIL to_no_dtack: dtack_low=%0d sel=%h want 0 00", dt_low, bus.s_sel);
    end
    repeat (3) tick();
    n_checks++;
    if (bus.berr_n !== 1'b0) begin
      n_fails++;
      $display("FAIL to_berr_hold: got %b want 0", bus.berr_n);
    end
    bus.s_ack = 8'h00;
    end_cycle("to");
  endtask

  task automatic test_unmapped();
    bit berr_seen = 0, sel_seen = 0;
    begin_cycle(19'h400, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int c = 0; c < 10 && !berr_seen; c++) begin
      tick();
      if (bus.s_sel !== 8'h00) sel_seen = 1;
      if (bus.berr_n === 1'b0) berr_seen = 1;
    end
    n_checks++;
    if (!berr_seen || sel_seen || bus.dtack_n !== 1'b1) begin
      n_fails++;
      $display("FAIL unmapped: berr=%0d sel_seen=%0d dtack_n=%b want 1 0 1", berr_seen, sel_seen, bus.dtack_n);
    end
    end_cycle("unmapped");
  endtask

  task automatic test_iack();
    bit found = 0, sel_seen = 0;
    bus.cpu_fc       = 3'b111;
    bus.intr_vector  = 8'h45;
    bus.intr_dtack_n = 1'b0;
    bus.intr_vpa_n   = 1'b1;
    begin_cycle(19'h25, 1'b1, 1'b1, 1'b0, 16'h0000);
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (bus.s_sel !== 8'h00) sel_seen = 1;
      if (bus.oe_l === 1'b1) found = 1;
    end
    n_checks++;
    if (!found || sel_seen || bus.cpu_rdata[7:0] !== 8'h45 || bus.oe_h !== 1'b0) begin
      n_fails++;
      $display("FAIL iack_vector: entered=%0d sel_seen=%0d rdata=%h oe_h=%b want 1 0 xx45 0",
               found, sel_seen, bus.cpu_rdata, bus.oe_h);
    end
    n_checks++;
    if (bus.dtack_n !== 1'b0 || bus.vpa_n !== 1'b1) begin
      n_fails++;
      $display("FAIL iack_pass1: dtack_n=%b vpa_n=%b want 0 1", bus.dtack_n, bus.vpa_n);
    end
    bus.intr_vpa_n   = 1'b0;
    bus.intr_dtack_n = 1'b1;
    #1;
    n_checks++;
    if (bus.dtack_n !== 1'b1 || bus.vpa_n !== 1'b0) begin
      n_fails++;
      $display("FAIL iack_pass2: dtack_n=%b vpa_n=%b want 1 0", bus.dtack_n, bus.vpa_n);
    end
    bus.intr_vpa_n = 1'b1;
    end_cycle("iack");
    bus.cpu_fc = 3'b101;
  endtask

  task automatic test_abort();
    bit found = 0, hs_seen = 0;
    logic [7:0] sel_s3;
    begin_cycle(19'h11, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int c = 0; c < 10 && !found; c++) begin
      tick();
      if (bus.s_sel === 8'h02) found = 1;
    end
    tick();
    bus.as_n = 1'b1;
    tick();
    tick();
    sel_s3 = bus.s_sel;
    tick();
    n_checks++;
    if (!found || sel_s3 !== 8'h02 || bus.s_sel !== 8'h00) begin
      n_fails++;
      $display("FAIL abort_sel: started=%0d sel_before=%h sel_after=%h want 1 02 00", found, sel_s3, bus.s_sel);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.dtack_n !== 1'b1 || bus.berr_n !== 1'b1) hs_seen = 1;
    end
    n_checks++;
    if (hs_seen) begin
      n_fails++;
      $display("FAIL abort_no_handshake: dtack or berr asserted after abort, want none");
    end
    end_cycle("abort");
  endtask

  task automatic test_reset_mid_done();
    bit found = 0, act = 0;
    begin_cycle(19'h25, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (bus.dtack_n === 1'b0) found = 1;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (!found || {bus.dtack_n, bus.berr_n, bus.vpa_n, bus.oe_h, bus.oe_l} !== 5'b11100) begin
      n_fails++;
      $display("FAIL rst_mid_hs: reached_done=%0d got %b want 11100", found,
               {bus.dtack_n, bus.berr_n, bus.vpa_n, bus.oe_h, bus.oe_l});
    end
    n_checks++;
    if (bus.s_sel !== 8'h00 || bus.s_addr !== 4'h0 || bus.s_be !== 2'b00 || bus.cpu_rdata !== 16'hFFFF) begin
      n_fails++;
      $display("FAIL rst_mid_regs: sel=%h addr=%h be=%b rdata=%h want 00 0 00 ffff",
               bus.s_sel, bus.s_addr, bus.s_be, bus.cpu_rdata);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus.s_sel !== 8'h00 || bus.dtack_n !== 1'b1 || bus.s_stb !== 1'b0) act = 1;
    end
    n_checks++;
    if (act) begin
      n_fails++;
      $display("FAIL rst_rearm: access started while strobe held through reset, want none");
    end
    end_cycle("rst_mid");
  endtask

  initial begin
    logic [15:0] w;
    bus.as_n = 1'b1;  bus.uds_n = 1'b1;  bus.lds_n = 1'b1;  bus.rw = 1'b1;
    bus.cpu_fc = 3'b101;  bus.fpga_cs_n = 1'b1;  bus.cpu_addr = '0;  bus.cpu_wdata = '0;
    bus.intr_vector = 8'h00;  bus.intr_dtack_n = 1'b1;  bus.intr_vpa_n = 1'b1;  bus.s_ack = '0;
    for (int i = 0; i < 8; i++) begin
      w = 16'hC000 | 16'(i * 16'h0111);
      bus.s_rdata[16*i +: 16] = w;
    end

    test_reset();
    test_fixed_read(19'h25, 8'h04, 16'hC222, "rd_s2");
    test_ack_write();
    test_timeout();
    test_unmapped();
    test_iack();
    test_abort();
    test_reset_mid_done();
    test_fixed_read(19'h30, 8'h08, 16'hC333, "rd_s3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/bus_bridge_gen.md
BUS_BRIDGE_GEN -- requirements
Module: bus_bridge_gen

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
 - SLOT_BITS, 3: log2 of slot count; NSLOT = 2**SLOT_BITS.
 - REG_BITS, 4: word-register address bits per slot.
 - ADDR_W, 19: width of CPU word address A[ADDR_W:1].
 - ACK_MASK, {NSLOT{1'b0}}: bit i=1 means slot i completes on s_ack[i]; bit i=0 means fixed wait.
 - WAIT_CYC, 2: fixed-wait cycles, 0..15.
 - TIMEOUT, 255: s_ack timeout in clk cycles, 1..1023.
REQ-002 SHALL have ports (name, direction, width, meaning):
 - clk, in, 1: sole clock.
 - rst, in, 1: reset.
 - as_n, in, 1: CPU address strobe, asynchronous.
 - uds_n / lds_n, in, 1 each: upper/lower data strobes.
 - rw, in, 1: 1 = read.
 - cpu_fc, in, 3: CPU function code.
 - fpga_cs_n, in, 1: region chip select.
 - cpu_addr, in, ADDR_W: word address.
 - cpu_wdata, in, 16: write data.
 - cpu_rdata, out, 16: read data.
 - oe_h / oe_l, out, 1 each: byte-lane drive enables.
 - dtack_n / berr_n / vpa_n, out, 1 each: CPU handshakes.
 - intr_vector, in, 8: interrupt vector.
 - intr_dtack_n / intr_vpa_n, in, 1 each: interrupt-controller handshakes.
 - s_sel, out, NSLOT: one-hot slot select.
 - s_stb, out, 1: access start pulse.
 - s_addr, out, REG_BITS: register address.
 - s_we, out, 1: write enable.
 - s_be, out, 2: byte enables {upper, lower}.
 - s_wdata, out, 16: slave write data.
 - s_rdata, in, NSLOT*16: slot i read data at [16i+15:16i].
 - s_ack, in, NSLOT: slave completion.
REQ-003 SHALL use one clock, clk; reset rst is asynchronous and active-high.

Function
REQ-004 SHALL synchronise as_n through two flops to as_s; all FSM decisions use as_s.
REQ-005 SHALL implement FSM states IDLE, ACCESS, DONE, BERR, IACK.
REQ-006 IDLE->IACK when as_s=0 and cpu_fc=3'b111; IACK has priority over every other condition.
REQ-007 IDLE->ACCESS when as_s=0, fpga_cs_n=0, cpu_fc!=3'b111, at least one data strobe low, and cpu_addr bits above SLOT_BITS+REG_BITS-1 are all zero.
REQ-008 IDLE->BERR under the REQ-007 conditions when any upper address bit is nonzero (unmapped).
REQ-009 On IDLE->ACCESS, SHALL latch:
 - slot = cpu_addr[SLOT_BITS+REG_BITS-1:REG_BITS]
 - s_addr = cpu_addr[REG_BITS-1:0]
 - s_we = ~rw
 - s_be = {~uds_n, ~lds_n}
 - s_wdata = cpu_wdata
REQ-010 s_sel SHALL be one-hot on the latched slot throughout ACCESS and zero otherwise; s_stb=1 on the first ACCESS cycle only.
REQ-011 Fixed-wait slot: ACCESS lasts exactly WAIT_CYC+1 cycles, then ->DONE.
REQ-012 Ack slot: ->DONE in the cycle after s_ack[slot]=1 is sampled; s_ack of non-selected slots is ignored.
REQ-013 Ack slot: a 10-bit counter, cleared on entry, ->BERR when it reaches TIMEOUT with no ack; ack and timeout in the same cycle resolve to DONE.
REQ-014 On ACCESS->DONE with a read, cpu_rdata SHALL capture the selected slot's s_rdata.
REQ-015 In DONE, dtack_n=0 (registered); oe_h=rw&s_be[1]; oe_l=rw&s_be[0].
REQ-016 In BERR, berr_n=0 and dtack_n=1.
REQ-017 DONE, BERR and IACK SHALL return to IDLE when as_s=1.
REQ-018 as_s=1 during ACCESS (abort): ->IDLE next cycle; s_sel cleared; no dtack; write data already strobed is not retracted.
REQ-019 In IACK: dtack_n=intr_dtack_n and vpa_n=intr_vpa_n combinationally; cpu_rdata[7:0]=intr_vector; oe_l=1; oe_h=0.
REQ-020 Outside IACK, vpa_n=1; outside DONE/IACK, dtack_n=1; outside DONE/IACK, oe_h=oe_l=0.
REQ-021 A new cycle is accepted only after as_s=1 has been seen (no back-to-back decode in one strobe).

Reset
REQ-022 rst=1 SHALL force, asynchronously:
 - state=IDLE
 - as_s=1
 - dtack_n=berr_n=vpa_n=1
 - s_sel=0, s_stb=0, s_we=0, s_be=0
 - s_addr=0, s_wdata=0
 - cpu_rdata=16'hFFFF
 - counters=0
 - oe_h=oe_l=0
REQ-023 rst asserted mid-access SHALL drop s_sel and dtack_n immediately; after release, the FSM waits for as_s=1 before accepting a cycle.

Verification
REQ-024 Fixed-wait word read, slot 2 reg 5: addr=0x25, rw=1, strobes low -> s_sel=8'h04 for 3 cycles, s_stb for 1 cycle, dtack_n=0, cpu_rdata=s_rdata[47:32], oe_h=oe_l=1.
REQ-025 Ack slot 1 (ACK_MASK=8'h02), upper-byte write 0xAB00: s_we=1, s_be=2'b10; s_ack after 5 cycles -> dtack_n=0 next cycle; no write on lower lane.
REQ-026 Ack slot with s_ack never asserted, TIMEOUT=10 -> berr_n=0 exactly 10 cycles after ACCESS entry; dtack_n stays 1; berr_n releases after as_n rises.
REQ-027 Unmapped address 0x400 with fpga_cs_n=0 -> BERR; s_sel never asserted.
REQ-028 IACK, cpu_fc=7, intr_vector=0x45, intr_dtack_n=0 -> cpu_rdata[7:0]=0x45, oe_l=1, dtack_n=0, vpa_n=intr_vpa_n.
REQ-029 as_n raised on the second ACCESS cycle -> IDLE, no dtack; rst pulse mid-DONE -> all outputs at reset values the same cycle.
